// File: rtl/pll_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding, loss-counter width
// and a counter-width helper.
package pll_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_QUALIFY   = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam int LOSS_CNT_W = 8;

  // Counter width for a count of n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit synchronizer of parameterized depth; resets to 0. Used for any PLL-side
// status that crosses into the system clock domain.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_lock_rst_seq.sv
// Qualifies PLL lock, releases staged active-low domain resets in order, and reports ready.
// Define PLL_LOCK_LOSS_CNT_EN to build the saturating lock-loss counter; otherwise it reads 0.
//
// state      | meaning
// WAIT_LOCK  | all resets held, waiting for synced lock
// QUALIFY    | counting consecutive lock cycles
// RELEASE    | releasing resets one per gap interval, bit 0 first
// RUN        | all resets released, ready asserted
module pll_lock_rst_seq
  import pll_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int LOCK_STABLE_CYC = 1000,
  parameter int NUM_RST         = 3,
  parameter int STAGE_GAP_CYC   = 8
) (
  input  logic                  IN_CLK_50M,
  input  logic                  IN_RST_N,
  input  logic                  IN_PLL_LOCKED,
  output logic [NUM_RST-1:0]    OUT_RST_N,
  output logic                  OUT_READY,
  output logic [1:0]            OUT_STATE,
  output logic [LOSS_CNT_W-1:0] OUT_LOCK_LOSS_CNT
);

  localparam int STAB_W = cnt_w(LOCK_STABLE_CYC);
  localparam int GAP_W  = cnt_w(STAGE_GAP_CYC);
  localparam int IDX_W  = cnt_w(NUM_RST);

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYC - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP_CYC - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_RST - 1);

  logic               lock_s;
  state_t             state;
  logic [STAB_W-1:0]  stab_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [IDX_W-1:0]   idx;
  logic [NUM_RST-1:0] rst_q;
  logic               ready_q;
  logic               loss_evt;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk   (IN_CLK_50M),
    .rst_n (IN_RST_N),
    .d     (IN_PLL_LOCKED),
    .q     (lock_s)
  );

  // Only a drop after qualification counts as a lock loss.
  assign loss_evt = !lock_s && (state == ST_RELEASE || state == ST_RUN);

  always_ff @(posedge IN_CLK_50M or negedge IN_RST_N) begin
    if (!IN_RST_N) begin
      state    <= ST_WAIT_LOCK;
      stab_cnt <= '0;
      gap_cnt  <= '0;
      idx      <= '0;
      rst_q    <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state)
        ST_WAIT_LOCK: begin
          rst_q   <= '0;
          ready_q <= 1'b0;
          if (lock_s) begin
            state    <= ST_QUALIFY;
            stab_cnt <= '0;
          end
        end
        ST_QUALIFY: begin
          if (!lock_s) begin
            state <= ST_WAIT_LOCK;
          end else if (stab_cnt == STAB_LAST) begin
            state   <= ST_RELEASE;
            gap_cnt <= '0;
            idx     <= '0;
          end else begin
            stab_cnt <= stab_cnt + STAB_W'(1);
          end
        end
        ST_RELEASE: begin
          if (!lock_s) begin
            state   <= ST_WAIT_LOCK;
            rst_q   <= '0;
            ready_q <= 1'b0;
          end else if (gap_cnt == GAP_LAST) begin
            // OR-ing in the next bit keeps the output a thermometer code.
            rst_q   <= rst_q | (NUM_RST'(1) << idx);
            gap_cnt <= '0;
            if (idx == IDX_LAST) begin
              state   <= ST_RUN;
              ready_q <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state   <= ST_WAIT_LOCK;
            rst_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state   <= ST_WAIT_LOCK;
          rst_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt;

  always_ff @(posedge IN_CLK_50M or negedge IN_RST_N) begin
    if (!IN_RST_N)                     loss_cnt <= '0;
    else if (loss_evt && loss_cnt != '1) loss_cnt <= loss_cnt + LOSS_CNT_W'(1);
  end

  assign OUT_LOCK_LOSS_CNT = loss_cnt;
`else
  logic unused_loss_evt;
  assign unused_loss_evt   = loss_evt;
  assign OUT_LOCK_LOSS_CNT = '0;
`endif

  assign OUT_RST_N = rst_q;
  assign OUT_READY = ready_q;
  assign OUT_STATE = state;

endmodule

// File: doc/pll_lock_rst_seq.md
# pll_lock_rst_seq

Reset sequencer that sits directly downstream of the PLL top. It consumes the PLL `locked` output and qualifies lock for a stable interval. It then releases a set of staged, active-low domain resets in order and reports readiness. On loss of lock it re-asserts all resets, and it counts lock-loss events for debug.

## Interface
- `SYNC_STAGES`, 2 — synchronizer depth for `IN_PLL_LOCKED` (≥2)
- `LOCK_STABLE_CYC`, 1000 — consecutive synced-lock cycles required (20 µs at 50 MHz); ≥1
- `NUM_RST`, 3 — number of staged reset outputs; ≥1
- `STAGE_GAP_CYC`, 8 — cycles between consecutive reset releases; ≥1

Ports:
- `IN_CLK_50M` in 1 — 50 MHz system clock
- `IN_RST_N` in 1 — asynchronous, active-low reset
- `IN_PLL_LOCKED` in 1 — PLL lock indicator, asynchronous to `IN_CLK_50M`
- `OUT_RST_N` out NUM_RST — staged domain resets, active low; bit 0 released first
- `OUT_READY` out 1 — all resets released, lock held
- `OUT_STATE` out 2 — FSM state: 0 WAIT_LOCK, 1 QUALIFY, 2 RELEASE, 3 RUN
- `OUT_LOCK_LOSS_CNT` out 8 — saturating lock-loss count

## Operation
- `lock_s` is the output of a SYNC_STAGES-deep flop chain on `IN_PLL_LOCKED`. All decisions use `lock_s` only.
- FSM:
  - **WAIT_LOCK**: all `OUT_RST_N`=0, `OUT_READY`=0. If `lock_s`=1, go to QUALIFY with the stable counter cleared.
  - **QUALIFY**: the stable counter increments while `lock_s`=1. When it equals LOCK_STABLE_CYC-1, go to RELEASE with stage index 0 and gap counter 0. If `lock_s`=0, return to WAIT_LOCK; the loss counter is not incremented.
  - **RELEASE**: the gap counter increments each cycle. When it equals STAGE_GAP_CYC-1, set `OUT_RST_N[idx]`=1, increment idx and clear the gap counter. The release of the last bit also enters RUN and sets `OUT_READY`=1 on the same edge.
  - **RUN**: hold all `OUT_RST_N`=1 and `OUT_READY`=1.
- Lock loss in RELEASE or RUN (`lock_s`=0):
  - Next edge: state becomes WAIT_LOCK, all `OUT_RST_N` go to 0, and `OUT_READY` goes to 0.
  - The loss counter increments by 1 and saturates at 255.
  - Lock loss overrides any release scheduled on the same edge.
- Released bits never re-deassert out of order. `OUT_RST_N` is always a thermometer code: `OUT_RST_N[i]`=1 implies `OUT_RST_N[j]`=1 for all j<i.
- Counter widths are `$clog2` of the respective parameter, minimum 1 bit.

## Timing
- Async reset values:
  - state WAIT_LOCK
  - sync flops 0
  - `OUT_RST_N`=0, `OUT_READY`=0, `OUT_STATE`=0, `OUT_LOCK_LOSS_CNT`=0
  - all counters 0
- Reset assertion mid-sequence takes effect immediately (asynchronous). Deassertion is assumed synchronous to the clock, handled upstream.
- `IN_PLL_LOCKED` rising to `lock_s` high: SYNC_STAGES edges. QUALIFY is entered one edge later.
- QUALIFY dwell is exactly LOCK_STABLE_CYC cycles with uninterrupted lock.
- `OUT_RST_N[k]` releases (k+1)·STAGE_GAP_CYC cycles after RELEASE entry. `OUT_READY` rises with `OUT_RST_N[NUM_RST-1]`.
- Lock-loss response: SYNC_STAGES+1 edges from `IN_PLL_LOCKED` falling to `OUT_RST_N` all 0.
- All outputs are registered.

## Configuration
- `PLL_LOCK_LOSS_CNT_EN`: when defined, the 8-bit saturating loss counter is implemented. When undefined, the counter logic is omitted and `OUT_LOCK_LOSS_CNT` is driven constant 8'd0. The port list is unchanged in both cases.

## Structure
- The shared package `pll_pkg` holds the state enum localparams (`ST_WAIT_LOCK`=2'd0, `ST_QUALIFY`=2'd1, `ST_RELEASE`=2'd2, `ST_RUN`=2'd3) and `LOSS_CNT_W`=8.
- One sub-module, `sync_bit`: a parameterized-depth single-bit synchronizer with async active-low reset to 0. It is reused wherever other blocks consume PLL-side status.

## Test plan
Bench parameters: SYNC_STAGES=2, LOCK_STABLE_CYC=10, STAGE_GAP_CYC=4, NUM_RST=3, `PLL_LOCK_LOSS_CNT_EN` defined. 50 MHz clock as in the top-level bench.

1. **Reset hold**: `IN_RST_N`=0 with lock=1 → all outputs at reset values; `OUT_STATE`=0 throughout.
2. **Clean bring-up**: lock rises at edge 0.
   - `OUT_STATE`=1 at edge 3 and =2 at edge 13.
   - `OUT_RST_N`=3'b001 at edge 17, 3'b011 at 21, 3'b111 at 25.
   - `OUT_READY`=1 at edge 25.
3. **Glitch during qualify**: lock drops for 1 cycle 5 cycles into QUALIFY → return to WAIT_LOCK; `OUT_LOCK_LOSS_CNT` stays 0; the full 10-cycle qualify restarts.
4. **Loss in RUN**: lock falls → `OUT_RST_N`=3'b000 and `OUT_READY`=0 three edges later; `OUT_LOCK_LOSS_CNT`=1. Relock repeats scenario 2 timing.
5. **Loss in RELEASE** on the edge where `OUT_RST_N[1]` would release → it stays 0; all bits are 0; count increments.
6. **Saturation and macro**: 260 lock-loss cycles → count holds at 255. Rebuild without the macro → count reads 0 and FSM behaviour is identical.
